// File: rtl/tc_pkg.sv
// Shared types and constants for the tensor-core GEMM issuer.
// Tile indices are row-major offsets into the 4x4 operand and result arrays.
package tc_pkg;

    localparam int unsigned MAT_N  = 4;
    localparam int unsigned TILE_N = 2;
    localparam int unsigned OP_W   = 16;
    localparam int unsigned ACC_W  = 32;
    localparam int unsigned N_OPS  = 8;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDrain
    } tc_issue_state_t;

    // Row-major index of the top-left element of 2x2 tile (row_hi, col_hi).
    function automatic logic [3:0] tile_base(input logic row_hi, input logic col_hi);
        return 4'((32'(row_hi) * MAT_N + 32'(col_hi)) * TILE_N);
    endfunction

endpackage

// File: rtl/tc_acc_bank.sv
// 16 x 32-bit accumulator: one 4-lane 2x2-tile write/add port, one read port.
// Additions wrap modulo 2^32.
module tc_acc_bank
    import tc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             wr_add,
    input  logic [3:0]       wr_base,
    input  logic [ACC_W-1:0] wr_c0,
    input  logic [ACC_W-1:0] wr_c1,
    input  logic [ACC_W-1:0] wr_c2,
    input  logic [ACC_W-1:0] wr_c3,
    input  logic [3:0]       rd_idx,
    output logic [ACC_W-1:0] rd_data
);

    logic [ACC_W-1:0] acc_q [MAT_N*MAT_N];
    logic [ACC_W-1:0] acc_d [MAT_N*MAT_N];
    logic [3:0]       lane_idx  [4];
    logic [ACC_W-1:0] lane_data [4];

    assign lane_idx[0]  = wr_base;
    assign lane_idx[1]  = wr_base + 4'd1;
    assign lane_idx[2]  = wr_base + 4'(MAT_N);
    assign lane_idx[3]  = wr_base + 4'(MAT_N + 1);
    assign lane_data[0] = wr_c0;
    assign lane_data[1] = wr_c1;
    assign lane_data[2] = wr_c2;
    assign lane_data[3] = wr_c3;

    always_comb begin
        acc_d = acc_q;
        if (wr_en) begin
            for (int l = 0; l < 4; l++) begin
                acc_d[lane_idx[l]] = wr_add ? acc_q[lane_idx[l]] + lane_data[l] : lane_data[l];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < MAT_N * MAT_N; e++) begin
                acc_q[e] <= '0;
            end
        end else begin
            acc_q <= acc_d;
        end
    end

    assign rd_data = acc_q[rd_idx];

endmodule

// File: rtl/tc_gemm_issuer.sv
// Sequences a 4x4 GEMM as eight 2x2 tile ops on the tensor core, then streams C out.
// Optional watchdog in WAIT enabled by defining TC_ISSUE_TIMEOUT_EN.
module tc_gemm_issuer
    import tc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_we,
    input  logic             ld_sel,
    input  logic [3:0]       ld_addr,
    input  logic [OP_W-1:0]  ld_data,
    input  logic             job_start,
    output logic             job_busy,
    output logic             job_done,
    output logic             job_err,
    output logic             tc_start,
    output logic [OP_W-1:0]  tc_a0,
    output logic [OP_W-1:0]  tc_a1,
    output logic [OP_W-1:0]  tc_a2,
    output logic [OP_W-1:0]  tc_a3,
    output logic [OP_W-1:0]  tc_b0,
    output logic [OP_W-1:0]  tc_b1,
    output logic [OP_W-1:0]  tc_b2,
    output logic [OP_W-1:0]  tc_b3,
    input  logic             tc_done,
    input  logic [ACC_W-1:0] tc_c0,
    input  logic [ACC_W-1:0] tc_c1,
    input  logic [ACC_W-1:0] tc_c2,
    input  logic [ACC_W-1:0] tc_c3,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data,
    output logic [3:0]       res_idx
);

    logic [OP_W-1:0] a_q [MAT_N*MAT_N];
    logic [OP_W-1:0] a_d [MAT_N*MAT_N];
    logic [OP_W-1:0] b_q [MAT_N*MAT_N];
    logic [OP_W-1:0] b_d [MAT_N*MAT_N];

    tc_issue_state_t state_q, state_d;
    logic [2:0]      n_q, n_d;
    logic [3:0]      idx_q, idx_d;
    logic            tc_start_q, tc_start_d;
    logic            res_valid_q, res_valid_d;
    logic            busy_q, busy_d;
    logic            acc_wr, acc_add;
    logic [ACC_W-1:0] acc_rd;
    logic [3:0]      a_base, b_base, c_base;
    logic            timeout;

    // Op n decodes as i = n[2], j = n[1], k = n[0]; k = 0 runs first per C tile.
    assign a_base = tile_base(n_q[2], n_q[0]);
    assign b_base = tile_base(n_q[0], n_q[1]);
    assign c_base = tile_base(n_q[2], n_q[1]);

    assign tc_a0 = a_q[a_base];
    assign tc_a1 = a_q[a_base + 4'd1];
    assign tc_a2 = a_q[a_base + 4'(MAT_N)];
    assign tc_a3 = a_q[a_base + 4'(MAT_N + 1)];
    assign tc_b0 = b_q[b_base];
    assign tc_b1 = b_q[b_base + 4'd1];
    assign tc_b2 = b_q[b_base + 4'(MAT_N)];
    assign tc_b3 = b_q[b_base + 4'(MAT_N + 1)];

`ifdef TC_ISSUE_TIMEOUT_EN
    localparam int unsigned ToW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [ToW-1:0] to_cnt_q, to_cnt_d;
    logic           err_q, err_d;

    assign timeout = (state_q == StWait) && !tc_done && (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        to_cnt_d = to_cnt_q;
        err_d    = err_q;
        if (state_q == StIssue) begin
            to_cnt_d = '0;
        end else if (state_q == StWait) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
        if (timeout) begin
            err_d = 1'b1;
        end else if (state_q == StIdle && job_start) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end

    assign job_err = err_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
    assign job_err            = 1'b0;
`endif

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        state_d = state_q;
        n_d     = n_q;
        idx_d   = idx_q;
        acc_wr  = 1'b0;
        acc_add = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ld_we) begin
                    if (ld_sel) begin
                        b_d[ld_addr] = ld_data;
                    end else begin
                        a_d[ld_addr] = ld_data;
                    end
                end
                if (job_start) begin
                    state_d = StIssue;
                    n_d     = '0;
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                if (tc_done) begin
                    acc_wr  = 1'b1;
                    acc_add = n_q[0];
                    if (n_q == 3'(N_OPS - 1)) begin
                        state_d = StDrain;
                        idx_d   = '0;
                    end else begin
                        n_d     = n_q + 3'd1;
                        state_d = StIssue;
                    end
                end else if (timeout) begin
                    state_d = StIdle;
                end
            end
            StDrain: begin
                if (res_ready) begin
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'(MAT_N * MAT_N - 1)) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        tc_start_d  = (state_d == StIssue);
        res_valid_d = (state_d == StDrain);
        busy_d      = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < MAT_N * MAT_N; e++) begin
                a_q[e] <= '0;
                b_q[e] <= '0;
            end
            state_q     <= StIdle;
            n_q         <= '0;
            idx_q       <= '0;
            tc_start_q  <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            state_q     <= state_d;
            n_q         <= n_d;
            idx_q       <= idx_d;
            tc_start_q  <= tc_start_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
        end
    end

    tc_acc_bank u_acc (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (acc_wr),
        .wr_add  (acc_add),
        .wr_base (c_base),
        .wr_c0   (tc_c0),
        .wr_c1   (tc_c1),
        .wr_c2   (tc_c2),
        .wr_c3   (tc_c3),
        .rd_idx  (idx_q),
        .rd_data (acc_rd)
    );

    assign tc_start  = tc_start_q;
    assign job_busy  = busy_q;
    assign res_valid = res_valid_q;
    assign res_idx   = res_valid_q ? idx_q : 4'd0;
    assign res_data  = res_valid_q ? acc_rd : '0;
    // Combinational so a job_start in the final-beat cycle still sees the block busy.
    assign job_done  = res_valid_q && res_ready && (idx_q == 4'(MAT_N * MAT_N - 1));

endmodule

// File: tb/tb_tc_gemm_issuer.sv
// Bench for tc_gemm_issuer: tensor-core responder plus matrix-level reference model.
// Timeout scenario runs only when TC_ISSUE_TIMEOUT_EN is defined.
module tb_tc_gemm_issuer;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_we, ld_sel;
    logic [3:0]  ld_addr;
    logic [15:0] ld_data;
    logic        job_start;
    logic        job_busy, job_done, job_err, tc_start;
    logic [15:0] tc_a0, tc_a1, tc_a2, tc_a3, tc_b0, tc_b1, tc_b2, tc_b3;
    logic        tc_done;
    logic [31:0] tc_c0, tc_c1, tc_c2, tc_c3;
    logic        res_valid, res_ready;
    logic [31:0] res_data;
    logic [3:0]  res_idx;

    tc_gemm_issuer #(.TIMEOUT_CYCLES(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .ld_we     (ld_we),
        .ld_sel    (ld_sel),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .job_start (job_start),
        .job_busy  (job_busy),
        .job_done  (job_done),
        .job_err   (job_err),
        .tc_start  (tc_start),
        .tc_a0     (tc_a0),
        .tc_a1     (tc_a1),
        .tc_a2     (tc_a2),
        .tc_a3     (tc_a3),
        .tc_b0     (tc_b0),
        .tc_b1     (tc_b1),
        .tc_b2     (tc_b2),
        .tc_b3     (tc_b3),
        .tc_done   (tc_done),
        .tc_c0     (tc_c0),
        .tc_c1     (tc_c1),
        .tc_c2     (tc_c2),
        .tc_c3     (tc_c3),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_idx   (res_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: buffer contents as they must be, full 4x4 product mod 2^32.
    logic [15:0] ma [16];
    logic [15:0] mb [16];
    logic [31:0] exp_c [16];
    logic [31:0] got [16];

    function automatic logic [31:0] mm(input int r, input int c);
        logic [31:0] s = 32'd0;
        for (int k = 0; k < 4; k++) begin
            s = s + 32'(ma[4*r+k]) * 32'(mb[4*k+c]);
        end
        return s;
    endfunction

    // Tensor-core responder: done 1 + [dmin..dmax] cycles after start.
    int tc_dmin = 0;
    int tc_dmax = 0;
    int tc_hold_n = -1;
    int tc_starts = 0;

    initial begin
        logic [15:0] a [4];
        logic [15:0] b [4];
        logic [31:0] r [4];
        int d, me;
        tc_done = 1'b0;
        tc_c0 = '0; tc_c1 = '0; tc_c2 = '0; tc_c3 = '0;
        forever begin
            @(negedge clk);
            if (tc_start === 1'b1 && rst === 1'b0) begin
                a[0] = tc_a0; a[1] = tc_a1; a[2] = tc_a2; a[3] = tc_a3;
                b[0] = tc_b0; b[1] = tc_b1; b[2] = tc_b2; b[3] = tc_b3;
                for (int y = 0; y < 2; y++) begin
                    for (int x = 0; x < 2; x++) begin
                        r[2*y+x] = 32'(a[2*y]) * 32'(b[x]) + 32'(a[2*y+1]) * 32'(b[2+x]);
                    end
                end
                me = tc_starts;
                tc_starts++;
                d = int'($urandom_range(32'(tc_dmax), 32'(tc_dmin)));
                @(posedge clk);
                repeat (d) @(posedge clk);
                #1;
                if (!rst && me != tc_hold_n) begin
                    tc_done = 1'b1;
                    tc_c0 = r[0]; tc_c1 = r[1]; tc_c2 = r[2]; tc_c3 = r[3];
                    @(posedge clk);
                    #1;
                    tc_done = 1'b0;
                    tc_c0 = $urandom; tc_c1 = $urandom; tc_c2 = $urandom; tc_c3 = $urandom;
                end
            end
        end
    end

    // Output stream checker.
    int          exp_idx = 0;
    int          beats = 0;
    int          dones = 0;
    int          done_cyc = -1;
    bit          any_valid = 1'b0;
    bit          pv_stall = 1'b0;
    logic [31:0] pv_data;
    logic [3:0]  pv_idx;

    always @(negedge clk) begin
        if (rst) begin
            pv_stall = 1'b0;
        end else begin
            if (pv_stall) begin
                check("stall_valid", 32'(res_valid), 32'd1);
                check("stall_data", res_data, pv_data);
                check("stall_idx", 32'(res_idx), 32'(pv_idx));
            end
            if (res_valid) begin
                any_valid = 1'b1;
                check("beat_idx", 32'(res_idx), 32'(exp_idx));
                check("beat_data", res_data, exp_c[exp_idx & 15]);
                got[res_idx] = res_data;
                if (res_ready) begin
                    check("job_done_on_beat", 32'(job_done), 32'(exp_idx == 15));
                    if (job_done) begin
                        dones++;
                        done_cyc = cyc;
                    end
                    exp_idx++;
                    beats++;
                end
            end else if (job_done) begin
                check("job_done_spurious", 32'(job_done), 32'd0);
                dones++;
            end
            pv_stall = res_valid && !res_ready;
            pv_data  = res_data;
            pv_idx   = res_idx;
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_tc_start"}, 32'(tc_start), 32'd0);
        check({tag, "_busy"}, 32'(job_busy), 32'd0);
        check({tag, "_done"}, 32'(job_done), 32'd0);
        check({tag, "_err"}, 32'(job_err), 32'd0);
        check({tag, "_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_data"}, res_data, 32'd0);
        check({tag, "_idx"}, 32'(res_idx), 32'd0);
        check({tag, "_ops"}, 32'(tc_a0 | tc_a1 | tc_a2 | tc_a3 | tc_b0 | tc_b1 | tc_b2 | tc_b3),
              32'd0);
    endtask

    // mode 0: A = identity, B = ramp; 1: all 0xFFFF; 2: random.
    task automatic load_mats(input int mode);
        for (int i = 0; i < 16; i++) begin
            case (mode)
                0: begin
                    ma[i] = (i / 4 == i % 4) ? 16'd1 : 16'd0;
                    mb[i] = 16'(i);
                end
                1: begin
                    ma[i] = 16'hFFFF;
                    mb[i] = 16'hFFFF;
                end
                default: begin
                    ma[i] = 16'($urandom);
                    mb[i] = 16'($urandom);
                end
            endcase
        end
        for (int i = 0; i < 32; i++) begin
            ld_we   = 1'b1;
            ld_sel  = (i >= 16);
            ld_addr = 4'(i % 16);
            ld_data = (i < 16) ? ma[i % 16] : mb[i % 16];
            @(posedge clk);
            #1;
        end
        ld_we = 1'b0;
    endtask

    task automatic run_job(input bit rdy_rand, input bit inject, input bit timing);
        int s, first_v;
        for (int i = 0; i < 16; i++) begin
            exp_c[i] = mm(i / 4, i % 4);
        end
        exp_idx = 0; beats = 0; dones = 0; done_cyc = -1; tc_starts = 0;
        any_valid = 1'b0; first_v = -1;
        check("idle_before_start", 32'(job_busy), 32'd0);
        job_start = 1'b1;
        s = cyc;
        @(posedge clk);
        #1;
        job_start = 1'b0;
        check("busy_rise", 32'(job_busy), 32'd1);
        check("err_cleared", 32'(job_err), 32'd0);
        for (int t = 0; t < 4000 && beats < 16; t++) begin
            res_ready = rdy_rand ? 1'($urandom_range(1, 0)) : 1'b1;
            ld_we     = 1'b0;
            job_start = 1'b0;
            if (inject && job_busy) begin
                ld_we     = 1'($urandom_range(1, 0));
                ld_sel    = 1'($urandom);
                ld_addr   = 4'($urandom);
                ld_data   = 16'($urandom);
                job_start = 1'($urandom_range(1, 0));
            end
            if (timing && res_valid && res_idx == 4'd15) job_start = 1'b1;
            if (res_valid && first_v < 0) first_v = cyc;
            @(posedge clk);
            #1;
        end
        ld_we = 1'b0; job_start = 1'b0; res_ready = 1'b0;
        check("beats", 32'(beats), 32'd16);
        check("done_count", 32'(dones), 32'd1);
        check("tc_starts", 32'(tc_starts), 32'd8);
        check("busy_fall", 32'(job_busy), 32'd0);
        if (timing) begin
            check("first_valid_latency", 32'(first_v - s), 32'd17);
            check("drain_cycles", 32'(done_cyc - s), 32'd32);
            @(posedge clk);
            #1;
            check("start_with_done_ignored", 32'(job_busy), 32'd0);
        end
    endtask

    initial begin
        int w, err_cyc;
        rst = 1'b1; ld_we = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
        job_start = 1'b0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_zero("reset");

        // Identity times ramp gives C = ramp.
        load_mats(0);
        check("model_ident", mm(2, 3), 32'd11);
        run_job(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) check("ident_lit", got[i], 32'(i));

        // All-ones operands exercise the 2^32 wrap.
        load_mats(1);
        check("model_wrap", mm(1, 2), 32'hFFF8_0004);
        run_job(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) check("wrap_lit", got[i], 32'hFFF8_0004);

        // Random operands, random backpressure and latency, ignored loads/starts, re-run.
        tc_dmax = 3;
        for (int it = 0; it < 4; it++) begin
            load_mats(2);
            run_job(1'b1, 1'b1, 1'b0);
            run_job(1'b1, 1'b1, 1'b0);
        end

        // Reset while waiting on op n = 3.
        load_mats(2);
        tc_dmin = 6; tc_dmax = 6;
        tc_starts = 0;
        job_start = 1'b1;
        @(posedge clk);
        #1;
        job_start = 1'b0;
        for (int t = 0; t < 200 && tc_starts < 4; t++) begin
            @(posedge clk);
            #1;
        end
        check("reach_op3", 32'(tc_starts), 32'd4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_zero("midjob_reset");
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("no_start_after_reset", 32'(tc_starts), 32'd4);
        tc_dmin = 0; tc_dmax = 0;
        for (int i = 0; i < 16; i++) begin
            ma[i] = '0;
            mb[i] = '0;
        end
        run_job(1'b0, 1'b0, 1'b0);
        load_mats(2);
        run_job(1'b1, 1'b0, 1'b0);

`ifdef TC_ISSUE_TIMEOUT_EN
        // tc_done withheld on op n = 2: watchdog aborts without draining.
        load_mats(2);
        tc_hold_n = 2;
        tc_starts = 0; dones = 0; any_valid = 1'b0;
        w = -1; err_cyc = -1;
        job_start = 1'b1;
        @(posedge clk);
        #1;
        job_start = 1'b0;
        for (int t = 0; t < 400 && !job_err; t++) begin
            if (w < 0 && tc_starts >= 3) w = cyc;
            @(posedge clk);
            #1;
        end
        if (job_err) err_cyc = cyc;
        check("timeout_err", 32'(job_err), 32'd1);
        check("timeout_latency", 32'(err_cyc - w), 32'd64);
        check("timeout_busy", 32'(job_busy), 32'd0);
        check("timeout_no_done", 32'(dones), 32'd0);
        check("timeout_no_valid", 32'(any_valid), 32'd0);
        check("timeout_starts", 32'(tc_starts), 32'd3);
        repeat (3) @(posedge clk);
        #1;
        check("err_sticky", 32'(job_err), 32'd1);
        tc_hold_n = -1;
        run_job(1'b1, 1'b0, 1'b0);
`else
        w = 0; err_cyc = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tc_gemm_issuer.md
# tc_gemm_issuer

Initiator-side sequencer for the SM tensor core's 2x2 tile start/done interface. Holds a 4x4 A and 4x4 B operand buffer (16-bit elements), breaks C = A·B into eight 2x2 tile products, and issues each to the tensor core. It collects and accumulates the 32-bit results, then streams the 16 C elements out over a valid/ready port. It sits between the SM operand-collector/register path and the tensor core.

## Interface
- TIMEOUT_CYCLES, 64: watchdog limit in WAIT; used only with TC_ISSUE_TIMEOUT_EN.
- clk  in  1  clock; one clock domain.
- rst  in  1  reset, synchronous, active-high.
- ld_we  in  1  operand-buffer write strobe.
- ld_sel  in  1  buffer select: 0 = A, 1 = B.
- ld_addr  in  4  element index, row-major (row = addr[3:2], col = addr[1:0]).
- ld_data  in  16  element value.
- job_start  in  1  single-cycle pulse that starts a job.
- job_busy  out  1  high from the accepted job_start until the last result beat is accepted.
- job_done  out  1  one-cycle pulse on acceptance of the last result beat.
- job_err  out  1  sticky timeout flag, cleared by an accepted job_start.
- tc_start  out  1  tensor-core start pulse.
- tc_a0..tc_a3  out  16 each  A tile operands.
- tc_b0..tc_b3  out  16 each  B tile operands.
- tc_done  in  1  tensor-core completion.
- tc_c0..tc_c3  in  32 each  tile results; valid while tc_done = 1.
- res_valid  out  1  result beat valid.
- res_ready  in  1  downstream ready.
- res_data  out  32  C element.
- res_idx  out  4  C element index, row-major.

## Operation
- States: IDLE, ISSUE, WAIT, DRAIN.
- IDLE:
  - ld_we writes A[ld_addr] or B[ld_addr].
  - job_start moves to ISSUE with op counter n = 0 and clears job_err.
- Op decode: i = n[2], j = n[1], k = n[0]. The op computes C tile (i,j) += A tile (i,k) · B tile (k,j).
- A tile mapping:
  - tc_a0 = A[2i][2k], tc_a1 = A[2i][2k+1]
  - tc_a2 = A[2i+1][2k], tc_a3 = A[2i+1][2k+1]
- B tile mapping is identical, using B[2k..2k+1][2j..2j+1].
- ISSUE: tc_start = 1 for exactly one cycle, operands valid in that cycle, then go to WAIT.
- Operand outputs are driven from the n decode in every state, so they stay stable through WAIT.
- WAIT: on tc_done, capture the results:
  - Destinations: c0 → C[2i][2j], c1 → C[2i][2j+1], c2 → C[2i+1][2j], c3 → C[2i+1][2j+1].
  - k = 0 overwrites the accumulator; k = 1 adds to it, mod 2^32 with no saturation.
  - If n = 7, go to DRAIN with the read index at 0; otherwise n++ and go to ISSUE.
- DRAIN:
  - res_valid = 1; res_data = C[idx], res_idx = idx.
  - On res_valid & res_ready: idx++.
  - On acceptance of idx 15: job_done pulses and the block returns to IDLE.
- Ignored inputs:
  - ld_we and job_start while job_busy = 1 are ignored.
  - tc_done outside WAIT is ignored.
- Operand buffers persist across jobs, so a job can be re-run without reloading.

## Timing
- Reset values:
  - All outputs 0; state IDLE; n = 0; idx = 0.
  - Operand buffers and accumulators are 0.
- Reset mid-job aborts immediately to IDLE with reset values and issues no further tc_start.
- job_busy rises the cycle after job_start.
- One op takes 1 ISSUE cycle plus the WAIT cycles. The tensor core's done arrives 1 cycle after start, so each op takes 2 cycles minimum.
- First res_valid appears at the earliest 17 cycles after job_start: 16 compute cycles plus 1.
- With res_ready held high, 16 beats transfer in 16 cycles.
- While res_valid = 1 and res_ready = 0, res_data and res_idx are held stable.
- job_start in the same cycle as the final job_done is ignored.

## Configuration
- TC_ISSUE_TIMEOUT_EN defined:
  - A counter runs in WAIT and resets on each ISSUE.
  - When it reaches TIMEOUT_CYCLES without tc_done, job_err is set, the block goes to IDLE without draining, and job_busy drops with no job_done.
- TC_ISSUE_TIMEOUT_EN undefined: WAIT waits indefinitely; job_err is tied to 0 and no counter is synthesized.

## Structure
- Package tc_pkg holds:
  - State enum tc_issue_state_t.
  - Constants MAT_N = 4, TILE_N = 2, OP_W = 16, ACC_W = 32, N_OPS = 8.
- One sub-module, tc_acc_bank: 16 × 32-bit accumulator with a 4-lane write/add port and a 1-lane read port.

## Test plan
- A = identity, B[r][c] = 4r + c → 16 beats with res_data = 0..15 and res_idx = 0..15; exactly 8 tc_start pulses.
- A = B = all 0xFFFF → every res_data = 0xFFF80004, which checks mod-2^32 wrap.
- Random A and B with res_ready toggling randomly → results match a reference model, each index appears once in order, and data is stable under stall.
- job_start and ld_we pulsed during ISSUE/WAIT → no effect on results or buffers, and the tc_start count stays 8.
- rst asserted while in WAIT at n = 3 → all outputs 0 next cycle; a fresh job then produces correct results.
- With TC_ISSUE_TIMEOUT_EN, tc_done withheld at n = 2 → job_err = 1 at 64 cycles, job_busy = 0, no job_done, and no res_valid.
